// File: rtl/alu.sv
// Signed two's-complement ALU with a single registered output stage.
// Define ALU_SATURATION_EN to clamp ADD/SUB/MUL to the signed range instead of wrapping.
module alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         enable_in,
    input  logic [2:0]                   opcode_in,
    input  logic signed [DATA_WIDTH-1:0] alu_input1,
    input  logic signed [DATA_WIDTH-1:0] alu_input2,
    output logic signed [DATA_WIDTH-1:0] alu_output
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_EQ  = 3'b011,
        OP_GT  = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } opcode_e;

    logic signed [DATA_WIDTH-1:0] w_add;
    logic signed [DATA_WIDTH-1:0] w_sub;
    logic signed [DATA_WIDTH-1:0] w_mul;
    logic signed [DATA_WIDTH-1:0] w_result;

`ifdef ALU_SATURATION_EN
    localparam int SW = DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] w_sum_wide;
    logic signed [SW-1:0] w_diff_wide;
    logic signed [PW-1:0] w_prod_wide;

    // One guard bit is enough for add/sub: overflow iff the top two bits disagree.
    function automatic logic signed [DATA_WIDTH-1:0] clamp_sum(input logic signed [SW-1:0] v);
        if (v[SW-1] != v[SW-2])
            return v[SW-1] ? SAT_MIN : SAT_MAX;
        return v[DATA_WIDTH-1:0];
    endfunction

    // Product fits when every bit from the result sign bit upward is a copy of it.
    function automatic logic signed [DATA_WIDTH-1:0] clamp_prod(input logic signed [PW-1:0] v);
        logic [PW-DATA_WIDTH:0] upper;
        upper = v[PW-1:DATA_WIDTH-1];
        if (upper == '0 || upper == '1)
            return v[DATA_WIDTH-1:0];
        return v[PW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    assign w_sum_wide  = SW'(alu_input1) + SW'(alu_input2);
    assign w_diff_wide = SW'(alu_input1) - SW'(alu_input2);
    assign w_prod_wide = PW'(alu_input1) * PW'(alu_input2);
    assign w_add       = clamp_sum(w_sum_wide);
    assign w_sub       = clamp_sum(w_diff_wide);
    assign w_mul       = clamp_prod(w_prod_wide);
`else
    // Low half of a two's-complement product is independent of operand sign extension.
    assign w_add = alu_input1 + alu_input2;
    assign w_sub = alu_input1 - alu_input2;
    assign w_mul = alu_input1 * alu_input2;
`endif

    always_comb begin
        w_result = '0;
        case (opcode_e'(opcode_in))
            OP_ADD:  w_result = w_add;
            OP_SUB:  w_result = w_sub;
            OP_MUL:  w_result = w_mul;
            OP_EQ:   w_result[0] = (alu_input1 == alu_input2);
            OP_GT:   w_result[0] = (alu_input1 > alu_input2);
            OP_AND:  w_result = alu_input1 & alu_input2;
            OP_OR:   w_result = alu_input1 | alu_input2;
            OP_XOR:  w_result = alu_input1 ^ alu_input2;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in)
            alu_output <= '0;
        else if (enable_in)
            alu_output <= w_result;
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences, and a
// randomized run against an integer-arithmetic reference model.
module tb_alu;

    localparam int W = 8;
`ifdef ALU_SATURATION_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clock_in;
    logic                reset_in;
    logic                enable_in;
    logic [2:0]          opcode_in;
    logic signed [W-1:0] alu_input1;
    logic signed [W-1:0] alu_input2;
    logic signed [W-1:0] alu_output;

    int n_checks;
    int n_fail;

    alu #(.DATA_WIDTH(W)) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .enable_in  (enable_in),
        .opcode_in  (opcode_in),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_output (alu_output)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        string               name;
        logic [2:0]          op;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] exp;
    } vec_t;

    vec_t tbl[19];

    // Reference: exact integer result, then wrap modulo 2^W or clamp to the signed range.
    function automatic logic signed [W-1:0] model(input int op, input int a, input int b);
        int r;
        int lo;
        int hi;
        lo = -(1 << (W - 1));
        hi = (1 << (W - 1)) - 1;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = (a == b) ? 1 : 0;
            4: r = (a > b) ? 1 : 0;
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
        endcase
        if (op <= 2) begin
            if (SAT) begin
                if (r > hi) r = hi;
                if (r < lo) r = lo;
            end else begin
                r = r & ((1 << W) - 1);
                if (r > hi) r = r - (1 << W);
            end
        end
        return W'(r);
    endfunction

    task automatic check(input string name, input logic signed [W-1:0] act,
                         input logic signed [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [2:0] op,
                        input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        @(negedge clock_in);
        reset_in   = rst;
        enable_in  = en;
        opcode_in  = op;
        alu_input1 = a;
        alu_input2 = b;
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        logic signed [W-1:0] exp_q;
        n_checks   = 0;
        n_fail     = 0;
        reset_in   = 1'b0;
        enable_in  = 1'b0;
        opcode_in  = 3'b000;
        alu_input1 = '0;
        alu_input2 = '0;

        tbl[0]  = '{"add_5_3",        3'b000,    5,    3,    8};
        tbl[1]  = '{"add_127_1",      3'b000,  127,    1, SAT ? 8'sd127 : -8'sd128};
        tbl[2]  = '{"sub_m128_1",     3'b001, -128,    1, SAT ? -8'sd128 : 8'sd127};
        tbl[3]  = '{"mul_m128_m128",  3'b010, -128, -128, SAT ? 8'sd127 : 8'sd0};
        tbl[4]  = '{"mul_16_16",      3'b010,   16,   16, SAT ? 8'sd127 : 8'sd0};
        tbl[5]  = '{"mul_m3_5",       3'b010,   -3,    5,  -15};
        tbl[6]  = '{"mul_16_m16",     3'b010,   16,  -16, SAT ? -8'sd128 : 8'sd0};
        tbl[7]  = '{"eq_7_7",         3'b011,    7,    7,    1};
        tbl[8]  = '{"eq_7_m7",        3'b011,    7,   -7,    0};
        tbl[9]  = '{"gt_m1_m128",     3'b100,   -1, -128,    1};
        tbl[10] = '{"gt_m128_127",    3'b100, -128,  127,    0};
        tbl[11] = '{"gt_5_5",         3'b100,    5,    5,    0};
        tbl[12] = '{"and_f0_3c",      3'b101, -16,   60,   8'sh30};
        tbl[13] = '{"or_f0_3c",       3'b110, -16,   60,   -4};
        tbl[14] = '{"xor_f0_3c",      3'b111, -16,   60,   -52};
        tbl[15] = '{"add_100_100",    3'b000,  100,  100, SAT ? 8'sd127 : -8'sd56};
        tbl[16] = '{"sub_m100_100",   3'b001, -100,  100, SAT ? -8'sd128 : 8'sd56};
        tbl[17] = '{"sub_3_10",       3'b001,    3,   10,   -7};
        tbl[18] = '{"mul_m11_m11",    3'b010,  -11,  -11, SAT ? 8'sd121 : 8'sd121};

        // Reset with arbitrary inputs, then first result one edge after release.
        step(1'b1, 1'b1, 3'b111, 8'sd55, -8'sd77);
        check("reset_clears", alu_output, 8'sd0);
        step(1'b0, 1'b1, 3'b000, 8'sd5, 8'sd3);
        check("post_reset_add", alu_output, 8'sd8);

        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            check(tbl[i].name, alu_output, tbl[i].exp);
        end

        // Enable hold: output must not follow new inputs while enable is low.
        step(1'b0, 1'b1, 3'b000, 8'sd10, 8'sd20);
        check("hold_setup_add", alu_output, 8'sd30);
        step(1'b0, 1'b0, 3'b001, 8'sd1, 8'sd2);
        check("hold_cycle1", alu_output, 8'sd30);
        step(1'b0, 1'b0, 3'b001, 8'sd1, 8'sd2);
        check("hold_cycle2", alu_output, 8'sd30);
        step(1'b0, 1'b1, 3'b001, 8'sd1, 8'sd2);
        check("hold_release_sub", alu_output, -8'sd1);

        // Reset beats enable; reset while disabled still clears.
        step(1'b1, 1'b1, 3'b000, 8'sd1, 8'sd1);
        check("reset_priority", alu_output, 8'sd0);
        step(1'b0, 1'b1, 3'b000, 8'sd1, 8'sd1);
        check("after_reset_add", alu_output, 8'sd2);
        step(1'b1, 1'b0, 3'b000, 8'sd9, 8'sd9);
        check("reset_while_disabled", alu_output, 8'sd0);

        // Randomized run tracking the expected register contents.
        exp_q = '0;
        for (int n = 0; n < 4000; n++) begin
            logic                rst;
            logic                en;
            logic [2:0]          op;
            logic signed [W-1:0] a;
            logic signed [W-1:0] b;
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 4) != 0);
            op  = 3'($urandom_range(0, 7));
            a   = W'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            if (rst)
                exp_q = '0;
            else if (en)
                exp_q = model(int'(op), int'(a), int'(b));
            step(rst, en, op, a, b);
            check("random", alu_output, exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
